// File: rtl/pixel_capture_scaled.sv
// rtl/pixel_capture_scaled.sv - camera byte-bus capture with decimation and arming into a BRAM write port
// Optional outputs frame_cnt/last_line_len/err_line_idx when CAPTURE_STATS_EN is defined.
module pixel_capture_scaled #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIM_LOG2 = 1,
  parameter int ADDR_W     = 17
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [7:0]        D,
  input  logic              href,
  input  logic              vsync,
  input  logic              fmt,
  input  logic              continuous,
  input  logic              arm,
  output logic [11:0]       RGB,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [11:0]       last_line_len,
  output logic [11:0]       err_line_idx
`endif
);

  localparam int COL_W = $clog2(H_ACTIVE + 2) + 1;
  localparam int ROW_W = $clog2(V_ACTIVE + 1) + 1;

  localparam logic [COL_W-1:0]  H_LAST   = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0]  H_SAT    = COL_W'(H_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_MASK = COL_W'((1 << DECIM_LOG2) - 1);
  localparam logic [ROW_W-1:0]  V_LAST   = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0]  ROW_MASK = ROW_W'((1 << DECIM_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t            state_q;
  logic              vsync_q, href_q;
  logic              phase_q;
  logic [7:0]        byte1_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       rgb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_en_q, frame_done_q, busy_q, line_err_q;
`ifdef CAPTURE_STATS_EN
  logic [15:0]       frame_cnt_q;
  logic [11:0]       last_line_len_q, err_line_idx_q;
`endif

  logic        frame_start_d, href_fall_d, store_d;
  logic [11:0] pixel_d;

  assign frame_start_d = vsync & ~vsync_q;
  assign href_fall_d   = href_q & ~href;
  // RGB565 mode keeps the top 4 bits of each 5/6/5 field.
  assign pixel_d = fmt ? {byte1_q[7:4], byte1_q[2:0], D[7], D[4:1]}
                       : {byte1_q[3:0], D};
  assign store_d = (col_q < H_LAST) && ((col_q & COL_MASK) == '0)
                && ((row_q & ROW_MASK) == '0);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      byte1_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      rgb_q        <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      line_err_q   <= 1'b0;
`ifdef CAPTURE_STATS_EN
      frame_cnt_q     <= '0;
      last_line_len_q <= '0;
      err_line_idx_q  <= '0;
`endif
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm || continuous) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
          end
          if (arm) begin
            line_err_q <= 1'b0;
`ifdef CAPTURE_STATS_EN
            err_line_idx_q <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (frame_start_d) begin
            state_q <= S_CAPTURE;
            phase_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (frame_start_d) begin
            // Truncated frame: flag it and start over at address 0.
            line_err_q <= 1'b1;
`ifdef CAPTURE_STATS_EN
            if (!line_err_q) err_line_idx_q <= 12'(row_q);
`endif
            phase_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
          end else if (!vsync) begin
            if (href) begin
              phase_q <= ~phase_q;
              if (!phase_q) begin
                byte1_q <= D;
              end else begin
                if (col_q != H_SAT) col_q <= col_q + COL_ONE;
                if (store_d) begin
                  rgb_q     <= pixel_d;
                  wr_addr_q <= addr_q;
                  wr_en_q   <= 1'b1;
                  addr_q    <= addr_q + ADDR_ONE;
                end
              end
            end else if (href_fall_d) begin
              if (col_q != H_LAST || phase_q) begin
                line_err_q <= 1'b1;
`ifdef CAPTURE_STATS_EN
                if (!line_err_q) err_line_idx_q <= 12'(row_q);
`endif
              end
`ifdef CAPTURE_STATS_EN
              last_line_len_q <= 12'(col_q);
`endif
              row_q   <= row_q + ROW_ONE;
              col_q   <= '0;
              phase_q <= 1'b0;
              if (row_q == V_LAST) begin
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
`ifdef CAPTURE_STATS_EN
                frame_cnt_q  <= frame_cnt_q + 16'd1;
`endif
              end
            end
          end
        end
        S_DONE: begin
          state_q <= continuous ? S_ARMED : S_IDLE;
          busy_q  <= continuous;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RGB        = rgb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign line_err   = line_err_q;
`ifdef CAPTURE_STATS_EN
  assign frame_cnt     = frame_cnt_q;
  assign last_line_len = last_line_len_q;
  assign err_line_idx  = err_line_idx_q;
`endif

endmodule
